ld_queue: RTL and testbench

LD_QUEUE -- requirements
Module: ld_queue

---
 rtl/ld_pkg.sv | 16 +
 rtl/ld_cache.sv | 83 ++++++++
 rtl/ld_queue.sv | 153 +++++++++++++++
 tb/tb_ld_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_pkg.sv
// Shared definitions for the load queue: load opcodes and the FSM state encoding.
package ld_pkg;

    localparam logic [3:0] OP_LD  = 4'd4;
    localparam logic [3:0] OP_LDR = 4'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR);
    endfunction

endpackage

// File: rtl/ld_cache.sv
// Fully-associative one-word data cache: combinational lookup, fill into the
// lowest free line (else the round-robin victim), and store-snoop invalidate.
module ld_cache
    import ld_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv_valid,
    input  logic [ADDR_W-1:0] inv_addr
);

    localparam int VW = (LINES > 1) ? $clog2(LINES) : 1;

    logic [LINES-1:0]  line_valid;
    logic [ADDR_W-1:0] line_addr [LINES];
    logic [DATA_W-1:0] line_data [LINES];
    logic [VW-1:0]     victim;
    logic [VW-1:0]     free_idx;
    logic              free_found;
    logic              fill_ok;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < LINES; i++) begin
            if (line_valid[i] && (line_addr[i] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = line_data[i];
            end
        end
    end

    // Scan downward so the lowest-index invalid line wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!line_valid[i]) begin
                free_found = 1'b1;
                free_idx   = VW'(i);
            end
        end
    end

    // A fill racing an invalidate of the same address must not leave the line valid.
    assign fill_ok = fill_en && !(inv_valid && (inv_addr == fill_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
            victim     <= '0;
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (inv_valid && line_valid[i] && (line_addr[i] == inv_addr)) begin
                    line_valid[i] <= 1'b0;
                end
            end
            if (fill_ok) begin
                if (free_found) begin
                    line_valid[free_idx] <= 1'b1;
                    line_addr[free_idx]  <= fill_addr;
                    line_data[free_idx]  <= fill_data;
                end else begin
                    line_valid[victim] <= 1'b1;
                    line_addr[victim]  <= fill_addr;
                    line_data[victim]  <= fill_data;
                    victim <= (victim == VW'(LINES - 1)) ? '0 : victim + VW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ld_queue.sv
// In-order load queue: accepts LD/LDR from the reservation stations, serves
// hits from ld_cache and misses from memory, completing strictly in order.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | head (if any) looked up in cache; hit completes, miss requests
// ST_WAIT | read issued for head; waiting for response with matching address
module ld_queue
    import ld_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int LINES  = 4,
    parameter int TAG_W  = 6,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [TAG_W-1:0]  rs_num,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] val0,
    input  logic [ADDR_W-1:0] val1,
    output logic              valid_out,
    output logic [TAG_W-1:0]  rs_num_out,
    output logic [3:0]        op_out,
    output logic [DATA_W-1:0] res_out,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready,
    input  logic              inv_valid,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic              busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [TAG_W-1:0]  q_tag  [DEPTH];
    logic [3:0]        q_op   [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    state_t            state;

    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] head_addr;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_data;
    logic              lookup_hit;
    logic              not_empty;
    logic              push;
    logic              pop;
    logic              do_hit;
    logic              do_miss;
    logic              do_resp;

    assign busy      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);
    assign push      = valid && !busy && is_load(op);
    assign acc_addr  = (op == OP_LDR) ? val0 + val1 : val0;
    assign head_addr = q_addr[rd_ptr];

    // A line being invalidated this cycle cannot serve the lookup.
    assign lookup_hit = cache_hit && !(inv_valid && (inv_addr == head_addr));
    assign do_hit     = (state == ST_IDLE) && not_empty && lookup_hit;
    assign do_miss    = (state == ST_IDLE) && not_empty && !lookup_hit;
    assign do_resp    = (state == ST_WAIT) && mem_ready && (mem_addr_out == head_addr);
    assign pop        = do_hit || do_resp;

    ld_cache #(
        .LINES (LINES),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_cache (
        .clk        (clk),
        .rst        (rst),
        .lookup_addr(head_addr),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .fill_en    (do_resp),
        .fill_addr  (head_addr),
        .fill_data  (mem_data_out),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_addr[wr_ptr] <= acc_addr;
                q_tag[wr_ptr]  <= rs_num;
                q_op[wr_ptr]   <= op;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            valid_out  <= 1'b0;
            mem_re     <= 1'b0;
            mem_raddr  <= '0;
            res_out    <= '0;
            op_out     <= '0;
            rs_num_out <= '1;
        end else begin
            valid_out <= 1'b0;
            mem_re    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (do_hit) begin
                        valid_out  <= 1'b1;
                        res_out    <= cache_data;
                        rs_num_out <= q_tag[rd_ptr];
                        op_out     <= q_op[rd_ptr];
                    end else if (do_miss) begin
                        mem_re    <= 1'b1;
                        mem_raddr <= head_addr;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (do_resp) begin
                        valid_out  <= 1'b1;
                        res_out    <= mem_data_out;
                        rs_num_out <= q_tag[rd_ptr];
                        op_out     <= q_op[rd_ptr];
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ld_queue.sv
// Directed self-checking bench for ld_queue with hand-computed expectations.
module tb_ld_queue;

    localparam int TAG_W  = 6;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [3:0] T_LD  = 4'd4;
    localparam logic [3:0] T_LDR = 4'd5;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [TAG_W-1:0]  rs_num;
    logic [3:0]        op;
    logic [ADDR_W-1:0] val0, val1;
    logic              valid_out;
    logic [TAG_W-1:0]  rs_num_out;
    logic [3:0]        op_out;
    logic [DATA_W-1:0] res_out;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_ready;
    logic              inv_valid;
    logic [ADDR_W-1:0] inv_addr;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ld_queue #(.DEPTH(4), .LINES(4), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .rs_num      (rs_num),
        .op          (op),
        .val0        (val0),
        .val1        (val1),
        .valid_out   (valid_out),
        .rs_num_out  (rs_num_out),
        .op_out      (op_out),
        .res_out     (res_out),
        .mem_re      (mem_re),
        .mem_raddr   (mem_raddr),
        .mem_addr_out(mem_addr_out),
        .mem_data_out(mem_data_out),
        .mem_ready   (mem_ready),
        .inv_valid   (inv_valid),
        .inv_addr    (inv_addr),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [TAG_W-1:0] t,
                         input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        valid  = 1'b1;
        op     = o;
        rs_num = t;
        val0   = a0;
        val1   = a1;
        tick();
        valid = 1'b0;
    endtask

    task automatic respond(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_ready    = 1'b1;
        mem_addr_out = a;
        mem_data_out = d;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [TAG_W-1:0] t,
                              input logic [3:0] o, input logic [DATA_W-1:0] d);
        check_val({tag, "_vout"}, 32'(valid_out), 32'd1);
        check_val({tag, "_res"}, 32'(res_out), 32'(d));
        check_val({tag, "_tag"}, 32'(rs_num_out), 32'(t));
        check_val({tag, "_op"}, 32'(op_out), 32'(o));
    endtask

    task automatic miss_seq(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        issue(T_LD, t, a, 16'h0);
        check_val({tag, "_n1_vout"}, 32'(valid_out), 32'd0);
        tick();
        check_val({tag, "_mem_re"}, 32'(mem_re), 32'd1);
        check_val({tag, "_raddr"}, 32'(mem_raddr), 32'(a));
        respond(a, d);
        check_done(tag, t, T_LD, d);
    endtask

    task automatic hit_seq(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        issue(T_LD, t, a, 16'h0);
        check_val({tag, "_n1_vout"}, 32'(valid_out), 32'd0);
        check_val({tag, "_n1_re"}, 32'(mem_re), 32'd0);
        tick();
        check_done(tag, t, T_LD, d);
        check_val({tag, "_n2_re"}, 32'(mem_re), 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; rs_num = '0; op = '0; val0 = '0; val1 = '0;
        mem_addr_out = '0; mem_data_out = '0; mem_ready = 1'b0;
        inv_valid = 1'b0; inv_addr = '0;
        tick();
        tick();
        check_val("rst_vout", 32'(valid_out), 32'd0);
        check_val("rst_mem_re", 32'(mem_re), 32'd0);
        check_val("rst_raddr", 32'(mem_raddr), 32'd0);
        check_val("rst_res", 32'(res_out), 32'd0);
        check_val("rst_op", 32'(op_out), 32'd0);
        check_val("rst_tag", 32'(rs_num_out), 32'h3F);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Miss then hit on 0x0040, with a non-matching response ignored in WAIT.
        issue(T_LD, 6'd3, 16'h0040, 16'h0);
        check_val("m1_n1_vout", 32'(valid_out), 32'd0);
        check_val("m1_n1_re", 32'(mem_re), 32'd0);
        tick();
        check_val("m1_re", 32'(mem_re), 32'd1);
        check_val("m1_raddr", 32'(mem_raddr), 32'h0040);
        respond(16'h0041, 16'h1111);
        check_val("m1_pulse", 32'(mem_re), 32'd0);
        check_val("m1_ignore", 32'(valid_out), 32'd0);
        respond(16'h0040, 16'hBEEF);
        check_done("m1", 6'd3, T_LD, 16'hBEEF);
        tick();
        check_val("m1_vout_drop", 32'(valid_out), 32'd0);
        check_val("m1_res_hold", 32'(res_out), 32'hBEEF);
        hit_seq("h1", 16'h0040, 6'd7, 16'hBEEF);

        // LDR address wraps modulo 2^16.
        issue(T_LDR, 6'd5, 16'hFFF0, 16'h0020);
        tick();
        check_val("ldr_re", 32'(mem_re), 32'd1);
        check_val("ldr_raddr", 32'(mem_raddr), 32'h0010);
        respond(16'h0010, 16'h5555);
        check_done("ldr", 6'd5, T_LDR, 16'h5555);

        // Non-load opcode is dropped.
        issue(4'd3, 6'd9, 16'h0099, 16'h0);
        tick();
        check_val("drop_vout", 32'(valid_out), 32'd0);
        check_val("drop_re", 32'(mem_re), 32'd0);

        // Round-robin eviction from a clean cache.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            miss_seq("ev_fill", ADDR_W'(i), TAG_W'(i), DATA_W'(16'h0100 + i));
        end
        hit_seq("ev_hit2", 16'h0002, 6'd12, 16'h0102);
        miss_seq("ev_miss1", 16'h0001, 6'd11, 16'h0201);
        hit_seq("ev_hit5", 16'h0005, 6'd15, 16'h0105);

        // Fill the queue while memory stalls; fifth request must be dropped.
        for (int i = 0; i < 4; i++) begin
            valid  = 1'b1;
            op     = T_LD;
            rs_num = TAG_W'(i);
            val0   = ADDR_W'(16'h0080 + i);
            tick();
        end
        rs_num = 6'd9;
        val0   = 16'h0090;
        check_val("full_busy", 32'(busy), 32'd1);
        tick();
        valid = 1'b0;
        check_val("full_busy2", 32'(busy), 32'd1);
        respond(16'h0080, 16'h00A0);
        check_done("full0", 6'd0, T_LD, 16'h00A0);
        check_val("full_busy_drop", 32'(busy), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_val("full_re", 32'(mem_re), 32'd1);
            check_val("full_raddr", 32'(mem_raddr), 32'(16'h0080 + k));
            respond(ADDR_W'(16'h0080 + k), DATA_W'(16'h00A0 + k));
            check_done("fullk", TAG_W'(k), T_LD, DATA_W'(16'h00A0 + k));
        end
        tick();
        check_val("fifth_vout", 32'(valid_out), 32'd0);
        check_val("fifth_re", 32'(mem_re), 32'd0);

        // Invalidate racing the fill of the same address.
        issue(T_LD, 6'd2, 16'h0040, 16'h0);
        tick();
        check_val("if_re", 32'(mem_re), 32'd1);
        inv_valid = 1'b1;
        inv_addr  = 16'h0040;
        respond(16'h0040, 16'hCAFE);
        inv_valid = 1'b0;
        check_done("if", 6'd2, T_LD, 16'hCAFE);
        miss_seq("if_after", 16'h0040, 6'd4, 16'hD00D);

        // Invalidate racing the lookup of a cached address forces a miss.
        issue(T_LD, 6'd6, 16'h0040, 16'h0);
        inv_valid = 1'b1;
        inv_addr  = 16'h0040;
        tick();
        inv_valid = 1'b0;
        check_val("il_vout", 32'(valid_out), 32'd0);
        check_val("il_re", 32'(mem_re), 32'd1);
        respond(16'h0040, 16'h7777);
        check_done("il", 6'd6, T_LD, 16'h7777);

        // Reset while waiting with three entries queued.
        inv_valid = 1'b1;
        inv_addr  = 16'h0040;
        tick();
        inv_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid  = 1'b1;
            op     = T_LD;
            rs_num = TAG_W'(i + 1);
            val0   = ADDR_W'(16'h0040 + i);
            tick();
        end
        valid = 1'b0;
        check_val("rw_busy3", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rw_busy", 32'(busy), 32'd0);
        check_val("rw_vout", 32'(valid_out), 32'd0);
        check_val("rw_tag", 32'(rs_num_out), 32'h3F);
        respond(16'h0040, 16'h1234);
        check_val("rw_stale", 32'(valid_out), 32'd0);
        tick();
        check_val("rw_stale2", 32'(valid_out), 32'd0);
        check_val("rw_re", 32'(mem_re), 32'd0);
        check_val("rw_res", 32'(res_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
